// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential signed divider.
// Holds the state encoding, the operand width and the iteration count.
package div_seq_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = $clog2(ITERATIONS);

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude as unsigned; INT_MIN maps onto itself, which is the correct unsigned 2^31.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor through a ripple of full-adder cells, keep the difference if non-negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic         quo_bit
);

    // One guard bit above the 33-bit remainder gives the sign of the trial difference.
    logic [W+1:0] shifted;
    logic [W+1:0] sub_b;
    logic [W+1:0] trial;
    logic [W+1:0] carry;

    assign shifted  = {rem, dividend_bit};
    assign sub_b    = ~{2'b00, divisor};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi <= W + 1; gi++) begin : g_fa
            assign trial[gi] = shifted[gi] ^ sub_b[gi] ^ carry[gi];
            if (gi < W + 1) begin : g_carry
                assign carry[gi+1] = (shifted[gi] & sub_b[gi]) |
                                     (carry[gi] & (shifted[gi] ^ sub_b[gi]));
            end
        end
    endgenerate

    assign quo_bit  = ~trial[W+1];
    assign rem_next = quo_bit ? trial[W:0] : shifted[W:0];

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit signed divider: magnitudes are divided by a 32-step restoring loop,
// then signs are restored so the quotient truncates toward zero and the remainder follows A.
module div_seq #(
    parameter int WIDTH = div_seq_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    import div_seq_pkg::*;

    state_t               state_reg;
    state_t               state_next;
    logic [COUNT_W-1:0]   count_reg;
    logic [WIDTH:0]       rem_reg;
    logic [WIDTH-1:0]     quo_reg;
    logic [WIDTH-1:0]     divisor_reg;
    logic [WIDTH-1:0]     dividend_reg;
    logic                 neg_a_reg;
    logic                 neg_q_reg;
    logic                 zero_reg;
    logic                 ovf_reg;

    logic [WIDTH:0]       rem_step;
    logic                 quo_bit;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    // quo_reg doubles as the dividend shift register: its MSB is the next bit to bring down.
    div_step #(.W(WIDTH)) u_step (
        .rem          (rem_reg),
        .dividend_bit (quo_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .rem_next     (rem_step),
        .quo_bit      (quo_bit)
    );

    assign quo_fixed = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_fixed = neg_a_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ctrl_DIV) begin
                    state_next = (data_operandB == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_reg == COUNT_W'(ITERATIONS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            divisor_reg    <= '0;
            dividend_reg   <= '0;
            neg_a_reg      <= 1'b0;
            neg_q_reg      <= 1'b0;
            zero_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_resultRDY <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ctrl_DIV) begin
                        dividend_reg <= data_operandA;
                        neg_a_reg    <= data_operandA[WIDTH-1];
                        neg_q_reg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        quo_reg      <= abs_val(data_operandA);
                        divisor_reg  <= abs_val(data_operandB);
                        rem_reg      <= '0;
                        count_reg    <= '0;
                        zero_reg     <= (data_operandB == '0);
                        ovf_reg      <= (data_operandA == INT_MIN) && (data_operandB == '1);
                    end
                end
                RUN: begin
                    rem_reg   <= rem_step;
                    quo_reg   <= {quo_reg[WIDTH-2:0], quo_bit};
                    count_reg <= count_reg + 1'b1;
                end
                DONE: begin
                    data_resultRDY <= 1'b1;
                    if (zero_reg) begin
                        data_result    <= '0;
                        data_remainder <= dividend_reg;
                        data_exception <= 1'b1;
                    end else if (ovf_reg) begin
                        data_result    <= INT_MIN;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quo_fixed;
                        data_remainder <= rem_fixed;
                        data_exception <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at start and
// compared (values and latency) whenever the divider pulses ready.
module tb_div_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    div_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          edge0;
        int          lat;
    } txn_t;

    txn_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic txn_t model(input logic [31:0] a, input logic [31:0] b);
        txn_t t;
        int   sa;
        int   sd;
        t.a     = a;
        t.b     = b;
        t.edge0 = 0;
        if (b == 32'd0) begin
            t.q = 32'd0; t.r = a; t.e = 1'b1; t.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            t.q = 32'h8000_0000; t.r = 32'd0; t.e = 1'b1; t.lat = 33;
        end else begin
            sa  = $signed(a);
            sd  = $signed(b);
            t.q = 32'(sa / sd);
            t.r = 32'(sa % sd);
            t.e = 1'b0;
            t.lat = 33;
        end
        return t;
    endfunction

    // Call away from a rising edge; the start is sampled on the next one.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        txn_t t;
        t = model(a, b);
        t.edge0 = cyc + 1;
        sb.push_back(t);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_val("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    logic prev_rdy = 1'b0;
    txn_t mon_t;

    always @(negedge clock) begin
        if (!reset) begin
            if (prev_rdy) check_val("rdy_pulse", {31'd0, data_resultRDY}, 32'd0);
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    check_val("spurious_rdy", {31'd0, data_resultRDY}, 32'd0);
                end else begin
                    mon_t = sb.pop_front();
                    check_val("result", data_result, mon_t.q);
                    check_val("remainder", data_remainder, mon_t.r);
                    check_val("exception", {31'd0, data_exception}, {31'd0, mon_t.e});
                    check_val("latency", 32'(cyc - mon_t.edge0), 32'(mon_t.lat));
                    $display("txn a=%h b=%h q=%h r=%h exc=%0d cyc=%0d",
                             mon_t.a, mon_t.b, data_result, data_remainder, data_exception, cyc);
                end
            end
        end
        prev_rdy = data_resultRDY;
    end

    logic [31:0] tbl_a [8] = '{32'd100, 32'hFFFF_FF9C, 32'd5, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tbl_b [8] = '{32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF,
                               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'h8000_0000};

    initial begin
        int e0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_result", data_result, 32'd0);
        check_val("rst_remainder", data_remainder, 32'd0);
        check_val("rst_exception", {31'd0, data_exception}, 32'd0);
        check_val("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Directed table: basic, negative, divide-by-zero, overflow, sign mixes, extremes
        for (int i = 0; i < 8; i++) begin
            start_op(tbl_a[i], tbl_b[i]);
            wait_drain(60);
        end

        // Busy start and operand changes are ignored; back-to-back start on the ready edge
        @(negedge clock);
        #1;
        start_op(32'd100, 32'd7);
        e0 = sb[0].edge0;
        while (cyc < e0 + 9) @(negedge clock);
        data_operandA = 32'd1234;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_drain(60);
        start_op(32'd9, 32'd3);
        wait_drain(60);

        // Reset mid-RUN aborts: outputs clear and no ready pulse follows
        @(negedge clock);
        #1;
        start_op(32'd100, 32'd7);
        e0 = sb[0].edge0;
        while (cyc < e0 + 14) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #1;
        check_val("abort_result", data_result, 32'd0);
        check_val("abort_remainder", data_remainder, 32'd0);
        check_val("abort_exception", {31'd0, data_exception}, 32'd0);
        check_val("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        start_op(32'd20, 32'd6);
        wait_drain(60);

        // Random operands
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (i % 4 == 3) rb = ~rb + 1'b1;
            start_op(ra, rb);
            wait_drain(60);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=%0d exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
